bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_pkg.sv | 28 ++
 rtl/stream_skid_fifo.sv | 61 ++++++
 rtl/bram_stream_reader.sv | 156 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and helpers for the BRAM burst stream reader.
// Holds the reader state encoding, FIFO sizing and the address-width helper.
// Contains no logic of its own.
package bram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Holding capacity downstream of the BRAM; the read credit is sized to this.
    localparam int FIFO_DEPTH = 4;

    // Number of bits needed to represent 'value' (at least 1 for value >= 1).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Four-entry FIFO buffering BRAM read data ahead of the output stream.
// Latency: a word written at a clock edge is visible on o_rd_dat the next cycle.
// Backpressure: pops only when o_rd_vld & i_rd_rdy; writes while full are dropped unless a pop coincides.
module stream_skid_fifo
#(
    parameter int WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_rdy,
    output logic [WIDTH-1:0] o_rd_dat,
    output logic             o_rd_vld,
    output logic [2:0]       o_count
);

    logic [WIDTH-1:0] r_mem [0:3];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [2:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_rd_rdy && (r_count != 3'd0);
    assign w_push = i_wr_vld && ((r_count != 3'd4) || w_pop);

    // Storage array; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    // Pointer and occupancy bookkeeping, cleared on reset so the FIFO reads as empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_rd_vld = (r_count != 3'd0);
    assign o_count  = r_count;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive BRAM words and streams them out with valid/ready.
// Latency: first m_valid_o four cycles after start acceptance; 1 word/cycle sustained.
// Backpressure: reads are issued only while FIFO count plus in-flight reads is below four.
module bram_stream_reader
    import bram_pkg::*;
#(
    parameter int NUM_COL   = 16,
    parameter int COL_WIDTH = 8,
    parameter int DEPTH     = 2048,
    parameter int ADDR_W    = clogb2(DEPTH - 1),
    parameter int WIDTH     = NUM_COL * COL_WIDTH
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    input  logic [ADDR_W:0]    len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic               mem_en_o,
    output logic [NUM_COL-1:0] mem_we_o,
    output logic [WIDTH-1:0]   mem_wdata_o,
    output logic               mem_oreg_en_o,
    output logic               mem_rst_o,
    input  logic [WIDTH-1:0]   mem_rdata_i,
    output logic [WIDTH-1:0]   m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i,
    output logic               m_last_o
);

    localparam logic [ADDR_W:0]   REMAIN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = ADDR_W'(DEPTH - 1);

    rd_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_remain;
    logic              r_busy;
    logic              r_done;
    // Two-stage shadow of the BRAM read pipeline: valid and end-of-burst flags.
    logic [1:0]        r_pipe_vld;
    logic [1:0]        r_pipe_last;

    logic              w_issue;
    logic              w_issue_last;
    logic [1:0]        w_inflight;
    logic [3:0]        w_outstanding;
    logic              w_credit_ok;
    logic [ADDR_W-1:0] w_addr_next;
    logic [2:0]        w_fifo_count;
    logic              w_fifo_vld;
    logic [WIDTH:0]    w_fifo_rdat;
    logic              w_pop;
    logic              w_last_hs;

    // Reads in the BRAM pipeline plus words already buffered must fit the FIFO.
    assign w_inflight    = {1'b0, r_pipe_vld[0]} + {1'b0, r_pipe_vld[1]};
    assign w_outstanding = {1'b0, w_fifo_count} + {2'b00, w_inflight};
    assign w_credit_ok   = (w_outstanding < 4'(FIFO_DEPTH));

    assign w_issue      = !rst && (r_state == READ) && (r_remain != '0) && w_credit_ok;
    assign w_issue_last = w_issue && (r_remain == REMAIN_ONE);
    assign w_addr_next  = (r_addr == ADDR_MAX) ? '0 : (r_addr + ADDR_W'(1));

    assign w_pop     = w_fifo_vld && m_ready_i;
    assign w_last_hs = w_pop && w_fifo_rdat[WIDTH];

    // Burst control FSM: accepts a start in IDLE, issues reads in READ, waits for the last word in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i == '0) begin
                            // Empty burst: complete immediately without touching the BRAM.
                            r_done <= 1'b1;
                        end else begin
                            r_state  <= READ;
                            r_addr   <= base_addr_i;
                            r_remain <= len_i;
                            r_busy   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_addr   <= w_addr_next;
                        r_remain <= r_remain - REMAIN_ONE;
                        if (w_issue_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_last_hs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Track each issued read through the two-cycle BRAM latency; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld  <= 2'b00;
            r_pipe_last <= 2'b00;
        end else begin
            r_pipe_vld  <= {r_pipe_vld[0], w_issue};
            r_pipe_last <= {r_pipe_last[0], w_issue_last};
        end
    end

    // The last flag rides alongside the data word as the FIFO's top bit.
    stream_skid_fifo #(
        .WIDTH (WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_wr_vld (r_pipe_vld[1]),
        .i_wr_dat ({r_pipe_last[1], mem_rdata_i}),
        .i_rd_rdy (m_ready_i),
        .o_rd_dat (w_fifo_rdat),
        .o_rd_vld (w_fifo_vld),
        .o_count  (w_fifo_count)
    );

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign mem_addr_o    = r_addr;
    assign mem_en_o      = w_issue;
    assign mem_we_o      = '0;
    assign mem_wdata_o   = '0;
    assign mem_oreg_en_o = 1'b1;
    assign mem_rst_o     = rst;

    assign m_valid_o = w_fifo_vld;
    assign m_data_o  = w_fifo_rdat[WIDTH-1:0];
    assign m_last_o  = w_fifo_vld && w_fifo_rdat[WIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;
    import bram_pkg::*;

    localparam int NUM_COL   = 16;
    localparam int COL_WIDTH = 8;
    localparam int DEPTH     = 2048;
    localparam int ADDR_W    = clogb2(DEPTH - 1);
    localparam int WIDTH     = NUM_COL * COL_WIDTH;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic [ADDR_W-1:0]  base_addr_i;
    logic [ADDR_W:0]    len_i;
    logic               busy_o;
    logic               done_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic               mem_en_o;
    logic [NUM_COL-1:0] mem_we_o;
    logic [WIDTH-1:0]   mem_wdata_o;
    logic               mem_oreg_en_o;
    logic               mem_rst_o;
    logic [WIDTH-1:0]   mem_rdata_i;
    logic [WIDTH-1:0]   m_data_o;
    logic               m_valid_o;
    logic               m_ready_i;
    logic               m_last_o;

    always #5 clk = ~clk;

    bram_stream_reader #(
        .NUM_COL   (NUM_COL),
        .COL_WIDTH (COL_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .len_i         (len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .mem_addr_o    (mem_addr_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_oreg_en_o (mem_oreg_en_o),
        .mem_rst_o     (mem_rst_o),
        .mem_rdata_i   (mem_rdata_i),
        .m_data_o      (m_data_o),
        .m_valid_o     (m_valid_o),
        .m_ready_i     (m_ready_i),
        .m_last_o      (m_last_o)
    );

    // Behavioural BRAM: array read at the address edge, output register one edge later.
    logic [WIDTH-1:0] bram [DEPTH];
    logic [WIDTH-1:0] bram_lat;
    initial begin
        for (int i = 0; i < DEPTH; i++) bram[i] = WIDTH'(i);
        bram_lat    = '0;
        mem_rdata_i = '0;
    end
    always @(posedge clk) begin
        if (mem_en_o) bram_lat <= bram[mem_addr_o];
        if (mem_oreg_en_o) mem_rdata_i <= mem_rst_o ? '0 : bram_lat;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [WIDTH:0] exp_q [$];
    int hs_count, issued, popped, max_out, first_vld_cyc, last_cyc, done_cyc;
    int done_count, en_count, vld_count, busy_count;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_dat;
    logic             prev_last;

    // Monitor / scoreboard: pops the expected queue on every handshake.
    always @(negedge clk) begin
        logic [WIDTH:0] exp_w;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (mem_en_o) begin issued++; en_count++; end
            if (busy_o) busy_count++;
            if (m_valid_o) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                vld_count++;
            end
            if (prev_stall) begin
                checks++;
                if (!m_valid_o || m_data_o !== prev_dat || m_last_o !== prev_last) begin
                    errors++;
                    $display("FAIL hold_stable: got vld=%b dat=%0h last=%b required vld=1 dat=%0h last=%b",
                             m_valid_o, m_data_o, m_last_o, prev_dat, prev_last);
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_dat   = m_data_o;
            prev_last  = m_last_o;
            if (m_valid_o && m_ready_i) begin
                popped++;
                hs_count++;
                if (m_last_o) last_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_word: got dat=%0h last=%b required no word", m_data_o, m_last_o);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({m_last_o, m_data_o} !== exp_w) begin
                        errors++;
                        $display("FAIL stream_word: got dat=%0h last=%b required dat=%0h last=%b",
                                 m_data_o, m_last_o, exp_w[WIDTH-1:0], exp_w[WIDTH]);
                    end
                end
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (done_o) begin
                done_count++;
                done_cyc = cyc;
                checks++;
                if (busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done: got %b required 0", busy_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic clear_obs();
        hs_count = 0; issued = 0; popped = 0; max_out = 0;
        first_vld_cyc = -1; last_cyc = -1; done_cyc = -1;
        done_count = 0; en_count = 0; vld_count = 0; busy_count = 0;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic launch(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len, output int acc);
        base_addr_i = base;
        len_i       = len;
        start_i     = 1'b1;
        acc         = cyc;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cyc < 0; i++) tick();
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: got no done_o within %0d cycles required done_o", budget);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        rst = 1'b1; start_i = 1'b0; base_addr_i = '0; len_i = '0; m_ready_i = 1'b1;
        clear_obs();

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("rst_busy",    busy_o,        0);
        check("rst_done",    done_o,        0);
        check("rst_valid",   m_valid_o,     0);
        check("rst_last",    m_last_o,      0);
        check("rst_mem_en",  mem_en_o,      0);
        check("rst_addr",    mem_addr_o,    0);
        check("rst_mem_rst", mem_rst_o,     1);
        check("oreg_en",     mem_oreg_en_o, 1);
        check("mem_we",      mem_we_o,      0);
        check("mem_wdata",   mem_wdata_o,   0);
        tick();
        rst = 1'b0;
        tick();

        // Burst 0x010..0x017 with ready held high
        clear_obs();
        push('h10, 0); push('h11, 0); push('h12, 0); push('h13, 0);
        push('h14, 0); push('h15, 0); push('h16, 0); push('h17, 1);
        launch(11'h010, 12'd8, acc);
        check("busy_after_start", busy_o, 1);
        wait_done(40);
        check("t1_first_valid_cyc", first_vld_cyc, acc + 4);
        check("t1_last_cyc",        last_cyc,      acc + 11);
        check("t1_done_cyc",        done_cyc,      acc + 12);
        check("t1_valid_cycles",    vld_count,     8);
        check("t1_words",           hs_count,      8);
        check("t1_done_count",      done_count,    1);
        check("t1_queue_empty",     exp_q.size(),  0);

        // Address wrap at the top of memory
        clear_obs();
        push('h7FE, 0); push('h7FF, 0); push('h000, 0); push('h001, 1);
        launch(11'h7FE, 12'd4, acc);
        wait_done(40);
        check("t2_words",       hs_count,     4);
        check("t2_queue_empty", exp_q.size(), 0);

        // Toggling ready with a 10-cycle stall
        clear_obs();
        for (int k = 0; k < 16; k++) push(WIDTH'('h200 + k), k == 15);
        launch(11'h200, 12'd16, acc);
        for (int k = 0; k < 300 && done_cyc < 0; k++) begin
            m_ready_i = (k >= 8 && k < 18) ? 1'b0 : k[0];
            tick();
        end
        m_ready_i = 1'b1;
        wait_done(20);
        check("t3_words",           hs_count,     16);
        check("t3_queue_empty",     exp_q.size(), 0);
        check("t3_max_outstanding", max_out,      4);

        // Zero-length burst
        clear_obs();
        launch(11'h055, 12'd0, acc);
        repeat (5) tick();
        check("t4_done_cyc",   done_cyc,   acc + 1);
        check("t4_done_count", done_count, 1);
        check("t4_mem_en",     en_count,   0);
        check("t4_valid",      vld_count,  0);
        check("t4_busy",       busy_count, 0);

        // Reset in the middle of a burst
        clear_obs();
        for (int k = 0; k < 10; k++) push(WIDTH'('h100 + k), k == 9);
        launch(11'h100, 12'd10, acc);
        for (int i = 0; i < 40 && hs_count < 3; i++) tick();
        check("t5_reach_word3", hs_count, 3);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy",   busy_o,     0);
        check("t5_done",   done_o,     0);
        check("t5_valid",  m_valid_o,  0);
        check("t5_last",   m_last_o,   0);
        check("t5_mem_en", mem_en_o,   0);
        check("t5_addr",   mem_addr_o, 0);
        tick();
        clear_obs();
        repeat (6) tick();
        check("t5_no_stale_valid", vld_count, 0);
        check("t5_no_stale_read",  en_count,  0);
        push('h0, 0); push('h1, 1);
        launch(11'h000, 12'd2, acc);
        wait_done(40);
        check("t5_words",       hs_count,     2);
        check("t5_queue_empty", exp_q.size(), 0);

        // Start pulsed again while busy must be ignored
        clear_obs();
        for (int k = 0; k < 6; k++) push(WIDTH'('h300 + k), k == 5);
        launch(11'h300, 12'd6, acc);
        tick();
        base_addr_i = 11'h400; len_i = 12'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(40);
        repeat (10) tick();
        check("t6_words",       hs_count,     6);
        check("t6_valid",       vld_count,    6);
        check("t6_reads",       en_count,     6);
        check("t6_done_count",  done_count,   1);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
